// File: rtl/weyl_pkg.sv
// Shared types and helpers for the Weyl stochastic bitstream blocks.
package weyl_pkg;

   localparam int BITSTREAM_DEF = 64;
   localparam int BASE_DEF      = 61;
   localparam int STRIDE_DEF    = 17;

   typedef enum logic {COLLECT, HOLD} weyl_dec_state_t;

   // Bit position that carries the i-th unit of quota in a Weyl frame.
   function automatic int unsigned weyl_idx(input int unsigned i,
                                            input int unsigned base      = BASE_DEF,
                                            input int unsigned stride    = STRIDE_DEF,
                                            input int unsigned bitstream = BITSTREAM_DEF);
      return (base + i * stride) % bitstream;
   endfunction

endpackage

// File: rtl/weyl_pattern_check.sv
// Combinational comparison of a received frame against the ideal Weyl
// pattern for quota q: bit[weyl_idx(i)] must equal (i < q) for every i.
module weyl_pattern_check
   import weyl_pkg::*;
#(
   parameter int BITSTREAM = BITSTREAM_DEF,
   parameter int BASE      = BASE_DEF,
   parameter int STRIDE    = STRIDE_DEF
) (
   input  logic [BITSTREAM-1:0]       frame,
   input  logic [$clog2(BITSTREAM):0] q,
   output logic                       mismatch
);

   localparam int IW = $clog2(BITSTREAM);

   logic [IW-1:0] pos;

   // Walk every quota unit; any bit disagreeing with the ideal pattern flags a mismatch.
   always_comb begin
      mismatch = 1'b0;
      pos      = '0;
      for (int i = 0; i < BITSTREAM; i++) begin
         pos = IW'(weyl_idx(i, BASE, STRIDE, BITSTREAM));
         if (frame[pos] != (i < int'(q)))
            mismatch = 1'b1;
      end
   end

endmodule

// File: rtl/weyl_stream_decoder.sv
// Weyl stochastic bitstream decoder: counts the ones in a BITSTREAM-bit
// serial frame and offers the count over a valid/ready handshake.
// Optional macro WEYL_CHECK_EN adds a frame store and a comparison against
// the ideal Weyl pattern, reported on out_mismatch.
module weyl_stream_decoder
   import weyl_pkg::*;
#(
   parameter int BITSTREAM = BITSTREAM_DEF,
   parameter int BASE      = BASE_DEF,
   parameter int STRIDE    = STRIDE_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic                       in_bit,
   output logic                       in_ready,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(BITSTREAM):0] out_count
`ifdef WEYL_CHECK_EN
   ,
   output logic                       out_mismatch
`endif
);

   localparam int IW = $clog2(BITSTREAM);
   localparam int CW = IW + 1;

   weyl_dec_state_t state, state_nxt;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   acc;
   logic [CW-1:0]   acc_nxt;
   logic            accept;
   logic            last_beat;
   logic            handshake;

   assign acc_nxt = acc + CW'(in_bit);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs; flush blocks acceptance in COLLECT.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last_beat = 1'b0;
      handshake = 1'b0;
      case (state)
         COLLECT: begin
            in_ready  = 1'b1;
            accept    = in_valid && !flush;
            last_beat = accept && (idx == IW'(BITSTREAM - 1));
            if (last_beat) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            handshake = out_ready;
            if (out_ready) state_nxt = COLLECT;
         end
      endcase
   end

   // Beat counter, ones accumulator and result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         acc       <= '0;
         out_count <= '0;
      end else if (flush && state == COLLECT) begin
         idx <= '0;
         acc <= '0;
      end else if (accept) begin
         idx <= idx + IW'(1);
         acc <= acc_nxt;
         if (last_beat) out_count <= acc_nxt;
      end else if (handshake) begin
         idx <= '0;
         acc <= '0;
      end
   end

`ifdef WEYL_CHECK_EN
   logic [BITSTREAM-1:0] frame;
   logic [BITSTREAM-1:0] frame_nxt;
   logic                 chk_mismatch;

   // Frame contents including the beat accepted this cycle, so the final bit is checked.
   always_comb begin
      frame_nxt = frame;
      if (accept) frame_nxt[idx] = in_bit;
   end

   weyl_pattern_check #(
      .BITSTREAM (BITSTREAM),
      .BASE      (BASE),
      .STRIDE    (STRIDE)
   ) u_check (
      .frame    (frame_nxt),
      .q        (acc_nxt),
      .mismatch (chk_mismatch)
   );

   // Frame store and mismatch flag, latched alongside out_count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame        <= '0;
         out_mismatch <= 1'b0;
      end else if (accept) begin
         frame <= frame_nxt;
         if (last_beat) out_mismatch <= chk_mismatch;
      end
   end
`endif

endmodule

// File: tb/tb_weyl_stream_decoder.sv
// Directed testbench for weyl_stream_decoder (BITSTREAM=64, BASE=61, STRIDE=17).
module tb_weyl_stream_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [6:0] out_count;
`ifdef WEYL_CHECK_EN
   logic       out_mismatch;
`endif

   int n_cmp = 0;
   int n_err = 0;

   weyl_stream_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
`ifdef WEYL_CHECK_EN
      ,
      .out_mismatch (out_mismatch)
`endif
   );

   always #5 clk = ~clk;

   // Ideal generator output for quota q.
   function automatic logic [63:0] weyl_pat(input int q);
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < 64; i++) p[(61 + i * 17) % 64] = (i < q);
      return p;
   endfunction

   // Send beats first..last of pat; ends on the negedge after the last accepted beat.
   task automatic send_bits(input logic [63:0] pat, input int first, input int last, input int gaps);
      for (int i = first; i <= last; i++) begin
         int budget;
         if (gaps != 0 && $urandom_range(0, 2) == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_bit   = pat[i];
         budget   = 0;
         while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
         end
         if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL in_ready_timeout: got %0b want 1 at beat %0d", in_ready, i);
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
      n_cmp++; if (out_count !== 7'd0)  begin n_err++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
`ifdef WEYL_CHECK_EN
      n_cmp++; if (out_mismatch !== 1'b0) begin n_err++; $display("FAIL rst_mismatch: got %0b want 0", out_mismatch); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_zeros();
      out_ready = 1'b1;
      send_bits(64'd0, 0, 62, 0);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zeros_early_valid: got %0b want 0", out_valid); end
      send_bits(64'd0, 63, 63, 0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zeros_valid: got %0b want 1", out_valid); end
      n_cmp++; if (out_count !== 7'd0) begin n_err++; $display("FAIL zeros_count: got %0d want 0", out_count); end
`ifdef WEYL_CHECK_EN
      n_cmp++; if (out_mismatch !== 1'b0) begin n_err++; $display("FAIL zeros_mismatch: got %0b want 0", out_mismatch); end
`endif
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zeros_release: got %0b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL zeros_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_quota37();
      logic [63:0] pat;
      pat = weyl_pat(37);
      out_ready = 1'b1;
      send_bits(pat, 0, 63, 0);
      n_cmp++; if (out_valid !== 1'b1)  begin n_err++; $display("FAIL q37_valid: got %0b want 1", out_valid); end
      n_cmp++; if (out_count !== 7'd37) begin n_err++; $display("FAIL q37_count: got %0d want 37", out_count); end
`ifdef WEYL_CHECK_EN
      n_cmp++; if (out_mismatch !== 1'b0) begin n_err++; $display("FAIL q37_mismatch: got %0b want 0", out_mismatch); end
`endif
      // quota unit 36 sits at bit 33 (a one), unit 37 at bit 50 (a zero): swap them
      pat[33] = 1'b0;
      pat[50] = 1'b1;
      send_bits(pat, 0, 63, 0);
      n_cmp++; if (out_count !== 7'd37) begin n_err++; $display("FAIL q37sw_count: got %0d want 37", out_count); end
`ifdef WEYL_CHECK_EN
      n_cmp++; if (out_mismatch !== 1'b1) begin n_err++; $display("FAIL q37sw_mismatch: got %0b want 1", out_mismatch); end
`endif
   endtask

   task automatic test_all_ones();
      out_ready = 1'b1;
      send_bits({64{1'b1}}, 0, 63, 0);
      n_cmp++; if (out_valid !== 1'b1)  begin n_err++; $display("FAIL ones_valid: got %0b want 1", out_valid); end
      n_cmp++; if (out_count !== 7'd64) begin n_err++; $display("FAIL ones_count: got %0d want 64", out_count); end
`ifdef WEYL_CHECK_EN
      n_cmp++; if (out_mismatch !== 1'b0) begin n_err++; $display("FAIL ones_mismatch: got %0b want 0", out_mismatch); end
`endif
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b0;
      send_bits(weyl_pat(10), 0, 63, 1);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if (out_valid !== 1'b1)  begin n_err++; $display("FAIL bp_valid: got %0b want 1 cycle %0d", out_valid, c); end
         n_cmp++; if (out_count !== 7'd10) begin n_err++; $display("FAIL bp_count: got %0d want 10 cycle %0d", out_count, c); end
         n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL bp_in_ready: got %0b want 0 cycle %0d", in_ready, c); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_bit   = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %0b want 0", out_valid); end
      send_bits(weyl_pat(3), 0, 63, 0);
      n_cmp++; if (out_count !== 7'd3) begin n_err++; $display("FAIL bp_next_count: got %0d want 3", out_count); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      send_bits(weyl_pat(50), 0, 19, 0);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
      out_ready = 1'b0;
      send_bits(weyl_pat(5), 0, 63, 0);
      n_cmp++; if (out_count !== 7'd5) begin n_err++; $display("FAIL flush_count: got %0d want 5", out_count); end
`ifdef WEYL_CHECK_EN
      n_cmp++; if (out_mismatch !== 1'b0) begin n_err++; $display("FAIL flush_mismatch: got %0b want 0", out_mismatch); end
`endif
      flush = 1'b1;
      repeat (2) @(negedge clk);
      flush = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_hold_valid: got %0b want 1", out_valid); end
      n_cmp++; if (out_count !== 7'd5) begin n_err++; $display("FAIL flush_hold_count: got %0d want 5", out_count); end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_release: got %0b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      send_bits({64{1'b1}}, 0, 29, 0);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after: got %0b want 0", out_valid); end
      send_bits(weyl_pat(12), 0, 63, 0);
      n_cmp++; if (out_valid !== 1'b1)  begin n_err++; $display("FAIL rstmid_q12_valid: got %0b want 1", out_valid); end
      n_cmp++; if (out_count !== 7'd12) begin n_err++; $display("FAIL rstmid_q12_count: got %0d want 12", out_count); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      send_bits(weyl_pat(7), 0, 63, 0);
      n_cmp++; if (out_count !== 7'd7) begin n_err++; $display("FAIL b2b_first: got %0d want 7", out_count); end
      send_bits(weyl_pat(63), 0, 63, 0);
      n_cmp++; if (out_count !== 7'd63) begin n_err++; $display("FAIL b2b_second: got %0d want 63", out_count); end
`ifdef WEYL_CHECK_EN
      n_cmp++; if (out_mismatch !== 1'b0) begin n_err++; $display("FAIL b2b_mismatch: got %0b want 0", out_mismatch); end
`endif
   endtask

   initial begin
      test_reset();
      test_zeros();
      test_quota37();
      test_all_ones();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
